// File: rtl/alu_cmd_driver_if.sv
// alu_cmd_driver_if: command and result valid/ready channels of the ALU command driver
interface alu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [7:0]  cmd_c;
  logic [1:0]  cmd_op;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_op;
  logic [7:0]  res_tag;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_data, res_op, res_tag
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_op, res_ready,
    output cmd_ready, res_valid, res_data, res_op, res_tag
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: drives one ALU command at a time, waits SETTLE_CYCLES, returns tagged ALU_OUT
// ALU_CMD_DRIVER_ACC_EN adds acc_clr/acc_out, a running 24-bit sum of captured results
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_cmd_driver_if.slave bus,
  output logic [7:0]      A,
  output logic [7:0]      B,
  output logic [7:0]      C,
  output logic            S0,
  output logic            S1,
  input  logic [15:0]     ALU_OUT
`ifdef ALU_CMD_DRIVER_ACC_EN
  ,
  input  logic            acc_clr,
  output logic [23:0]     acc_out
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t     state, next;
  logic [3:0] cnt;
  logic [7:0] tag;
  logic       accept, capture, give;
  always_comb begin
    accept  = state == IDLE && bus.cmd_valid && bus.cmd_ready;
    capture = state == SETTLE && cnt == 4'd0;
    give    = state == HOLD && bus.res_valid && bus.res_ready;
    next    = accept ? SETTLE : capture ? HOLD : give ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next;
  // handshake flags are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {A, B, C, S0, S1} <= '0;
      cnt <= '0;
      tag <= '0;
      bus.cmd_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_op    <= '0;
      bus.res_tag   <= '0;
    end else begin
      bus.cmd_ready <= next == IDLE;
      bus.res_valid <= next == HOLD;
      if (accept) begin
        {A, B, C} <= {bus.cmd_a, bus.cmd_b, bus.cmd_c};
        S0  <= bus.cmd_op[1];
        S1  <= bus.cmd_op[0];
        cnt <= 4'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        bus.res_data <= ALU_OUT;
        bus.res_op   <= {S0, S1};
        bus.res_tag  <= tag;
        tag          <= tag + 8'd1;
      end
    end
`ifdef ALU_CMD_DRIVER_ACC_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       acc_out <= '0;
    else if (acc_clr) acc_out <= capture ? {8'b0, ALU_OUT} : '0;
    else if (capture) acc_out <= acc_out + {8'b0, ALU_OUT};
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized checks of alu_cmd_driver (SETTLE_CYCLES 1 and 3) against a transaction-level model
module tb_alu_cmd_driver;
  logic clk = 0, rst_n = 0, sel = 0, cv = 0, rr = 0;
  logic [7:0] ca = 0, cb = 0, cc = 0;
  logic [1:0] cop = 0;
  logic [7:0] a1, b1, c1, a3, b3, c3;
  logic s01, s11, s03, s13;
  logic [15:0] alu1, alu3;
  int vectors = 0, miscompares = 0;
  int tagc [2] = '{0, 0};
  alu_cmd_driver_if i1 ();
  alu_cmd_driver_if i3 ();
`ifdef ALU_CMD_DRIVER_ACC_EN
  logic acc_clr = 0;
  logic [23:0] acc1, acc3;
`endif
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, b, c, input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = a * b;
      2'b01:   r = a - c;
      2'b10:   r = {24'b0, a ~^ b ~^ c};
      default: r = a[0] ? b + c : b - c;
    endcase
    return r[15:0];
  endfunction

  assign alu1 = alu_ref(a1, b1, c1, {s01, s11});
  assign alu3 = alu_ref(a3, b3, c3, {s03, s13});
  assign i1.cmd_valid = cv & ~sel;
  assign i3.cmd_valid = cv & sel;
  assign i1.res_ready = rr & ~sel;
  assign i3.res_ready = rr & sel;
  assign {i1.cmd_a, i1.cmd_b, i1.cmd_c, i1.cmd_op} = {ca, cb, cc, cop};
  assign {i3.cmd_a, i3.cmd_b, i3.cmd_c, i3.cmd_op} = {ca, cb, cc, cop};

  alu_cmd_driver #(.SETTLE_CYCLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .bus(i1),
    .A(a1), .B(b1), .C(c1), .S0(s01), .S1(s11), .ALU_OUT(alu1)
`ifdef ALU_CMD_DRIVER_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc1)
`endif
  );
  alu_cmd_driver #(.SETTLE_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .bus(i3),
    .A(a3), .B(b3), .C(c3), .S0(s03), .S1(s13), .ALU_OUT(alu3)
`ifdef ALU_CMD_DRIVER_ACC_EN
    , .acc_clr(1'b0), .acc_out(acc3)
`endif
  );

  logic        o_ready, o_valid;
  logic [15:0] o_data;
  logic [1:0]  o_op;
  logic [7:0]  o_tag;
  logic [25:0] o_abcs;
  assign o_ready = sel ? i3.cmd_ready : i1.cmd_ready;
  assign o_valid = sel ? i3.res_valid : i1.res_valid;
  assign o_data  = sel ? i3.res_data  : i1.res_data;
  assign o_op    = sel ? i3.res_op    : i1.res_op;
  assign o_tag   = sel ? i3.res_tag   : i1.res_tag;
  assign o_abcs  = sel ? {a3, b3, c3, s03, s13} : {a1, b1, c1, s01, s11};

  // One full command/result exchange on the selected driver; stall<0 keeps res_ready high from accept on.
  task automatic xact(input logic [7:0] a, b, c, input logic [1:0] op, input int stall);
    logic [25:0] opnd;
    logic [26:0] res;
    int settle, k;
    opnd = {a, b, c, op};
    res = {1'b1, alu_ref(a, b, c, op), op, 8'(tagc[sel])};
    settle = sel ? 3 : 1;
    k = 0;
    while (o_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_ready_wait got %b exp 1", o_ready); end
    {ca, cb, cc, cop} = opnd;
    cv = 1;
    rr = stall < 0;
    @(negedge clk);
    cv = 0;
    {ca, cb, cc, cop} = 26'($urandom);
    for (int j = 0; j < settle; j++) begin
      vectors++;
      if ({o_ready, o_valid} !== 2'b00) begin
        miscompares++; $display("FAIL settle_flags sel=%0d cycle %0d got %b exp 00", sel, j, {o_ready, o_valid});
      end
      @(negedge clk);
    end
    vectors++;
    if ({o_valid, o_data, o_op, o_tag} !== res) begin
      miscompares++; $display("FAIL result sel=%0d got %h exp %h", sel, {o_valid, o_data, o_op, o_tag}, res);
    end
    vectors++;
    if (o_abcs !== opnd) begin miscompares++; $display("FAIL operands got %h exp %h", o_abcs, opnd); end
    tagc[sel] = (tagc[sel] + 1) % 256;
    for (int j = 0; j < stall; j++) begin
      cv = j == stall / 2;
      {ca, cb, cc, cop} = 26'($urandom);
      @(negedge clk);
      vectors++;
      if ({o_ready, o_valid, o_data, o_op, o_tag, o_abcs} !== {1'b0, res, opnd}) begin
        miscompares++;
        $display("FAIL hold cycle %0d got %h exp %h", j, {o_ready, o_valid, o_data, o_op, o_tag, o_abcs}, {1'b0, res, opnd});
      end
    end
    cv = 0;
    rr = 1;
    @(negedge clk);
    rr = 0;
    vectors++;
    if ({o_ready, o_valid, o_abcs} !== {2'b10, opnd}) begin
      miscompares++; $display("FAIL release got %h exp %h", {o_ready, o_valid, o_abcs}, {2'b10, opnd});
    end
  endtask

  task automatic test_reset();
    logic [107:0] st;
    rst_n = 0; cv = 0; rr = 0;
    tagc = '{0, 0};
    repeat (3) @(negedge clk);
    st = {i1.cmd_ready, i1.res_valid, i1.res_data, i1.res_op, i1.res_tag, a1, b1, c1, s01, s11,
          i3.cmd_ready, i3.res_valid, i3.res_data, i3.res_op, i3.res_tag, a3, b3, c3, s03, s13};
    vectors++;
    if (st !== '0) begin miscompares++; $display("FAIL reset_outputs got %h exp 0", st); end
`ifdef ALU_CMD_DRIVER_ACC_EN
    vectors++;
    if (acc1 !== '0) begin miscompares++; $display("FAIL reset_acc got %h exp 0", acc1); end
`endif
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({i1.cmd_ready, i3.cmd_ready, i1.res_valid, i3.res_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL release_ready got %b exp 1100", {i1.cmd_ready, i3.cmd_ready, i1.res_valid, i3.res_valid});
    end
  endtask

  task automatic test_mul();
    sel = 0;
    xact(8'd12, 8'd10, 8'($urandom), 2'b00, 0);
  endtask

  task automatic test_sub_backpressure();
    sel = 0;
    xact(8'd5, 8'($urandom), 8'd7, 2'b01, 5);
  endtask

  task automatic test_cond();
    sel = 1;
    xact(8'd1, 8'd200, 8'd100, 2'b11, 1);
    xact(8'd0, 8'd200, 8'd100, 2'b11, 0);
    xact(8'($urandom), 8'($urandom), 8'($urandom), 2'b10, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom);
      xact(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 4)) - 1);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    sel = 0;
    for (int n = 0; n < 257; n++) xact(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), -1);
  endtask

  task automatic test_mid_reset();
    sel = 1;
    {ca, cb, cc, cop} = {8'd3, 8'd4, 8'd5, 2'b00};
    cv = 1;
    @(negedge clk);
    cv = 0;
    rst_n = 0;
    #1;
    vectors++;
    if ({i3.cmd_ready, i3.res_valid, i3.res_data, i3.res_tag, a3, b3, c3, s03, s13} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %h exp 0", {i3.cmd_ready, i3.res_valid, i3.res_data, i3.res_tag, a3, b3, c3, s03, s13});
    end
    @(negedge clk);
    rst_n = 1;
    tagc = '{0, 0};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      vectors++;
      if (i3.res_valid !== 1'b0) begin miscompares++; $display("FAIL dropped_result got %b exp 0", i3.res_valid); end
    end
    xact(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 0);
  endtask

`ifdef ALU_CMD_DRIVER_ACC_EN
  task automatic test_acc();
    test_reset();
    sel = 0;
    xact(8'd12, 8'd10, 8'd0, 2'b00, 0);
    xact(8'd5, 8'd0, 8'd7, 2'b01, 0);
    vectors++;
    if (acc1 !== 24'h010076) begin miscompares++; $display("FAIL acc_sum got %h exp 010076", acc1); end
    {ca, cb, cc, cop} = {8'd200, 8'd3, 8'd0, 2'b00};
    cv = 1;
    @(negedge clk);
    cv = 0;
    acc_clr = 1;
    @(negedge clk);
    acc_clr = 0;
    vectors++;
    if (acc1 !== 24'h000258) begin miscompares++; $display("FAIL acc_clr_capture got %h exp 000258", acc1); end
    rr = 1;
    @(negedge clk);
    rr = 0;
    tagc[0] = tagc[0] + 1;
    acc_clr = 1;
    @(negedge clk);
    acc_clr = 0;
    vectors++;
    if (acc1 !== 24'h0) begin miscompares++; $display("FAIL acc_clr got %h exp 0", acc1); end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_sub_backpressure();
    test_cond();
    test_random();
    test_back_to_back();
    test_mid_reset();
`ifdef ALU_CMD_DRIVER_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
